// File: rtl/ibex_dbus_arb_pkg.sv
// Shared types and limits for the two-host data-bus arbiter.
package ibex_dbus_arb_pkg;

  typedef enum logic {
    HOST_LSU = 1'b0,
    HOST_AUX = 1'b1
  } host_id_e;

  localparam int unsigned MaxOutstandingLimit = 4;

endpackage

// File: rtl/ibex_dbus_arb_owner_fifo.sv
// In-order record of which host owns each granted-but-unanswered transaction.
module ibex_dbus_arb_owner_fifo
  import ibex_dbus_arb_pkg::*;
#(
  parameter  int unsigned Depth = 2,
  localparam int unsigned CntW  = $clog2(Depth + 1),
  localparam int unsigned PtrW  = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  host_id_e        push_id_i,
  input  logic            pop_i,
  output host_id_e        head_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  host_id_e            mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]     count_q;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= HOST_LSU;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_id_i;
        wr_ptr_q        <= next_ptr(wr_ptr_q);
      end
      if (pop_i) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/ibex_data_bus_arb.sv
// Two-host req/gnt/rvalid arbiter in front of the core data port.
// Define IBEX_DBUS_ARB_RR_EN for round-robin; default is fixed priority to host 0.
module ibex_data_bus_arb
  import ibex_dbus_arb_pkg::*;
#(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        h0_req_i,
  output logic        h0_gnt_o,
  input  logic [31:0] h0_addr_i,
  input  logic        h0_we_i,
  input  logic [3:0]  h0_be_i,
  input  logic [31:0] h0_wdata_i,
  output logic        h0_rvalid_o,
  output logic [31:0] h0_rdata_o,
  output logic        h0_err_o,

  input  logic        h1_req_i,
  output logic        h1_gnt_o,
  input  logic [31:0] h1_addr_i,
  input  logic        h1_we_i,
  input  logic [3:0]  h1_be_i,
  input  logic [31:0] h1_wdata_i,
  output logic        h1_rvalid_o,
  output logic [31:0] h1_rdata_o,
  output logic        h1_err_o,

  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i,

  output logic        busy_o,
  output logic        unexp_rsp_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  host_id_e        winner, head_id, sticky_id_q, both_pick;
  logic            win_vld, sticky_vld_q, sticky_hit;
  logic            handshake, rsp_vld;
  logic            fifo_full, fifo_empty;
  logic [CntW-1:0] fifo_count;

`ifdef IBEX_DBUS_ARB_RR_EN
  host_id_e rr_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_q <= HOST_LSU;
    end else if (handshake) begin
      rr_q <= (rr_q == HOST_LSU) ? HOST_AUX : HOST_LSU;
    end
  end

  assign both_pick = rr_q;
`else
  assign both_pick = HOST_LSU;
`endif

  // A sticky host that dropped its request loses its claim this very cycle.
  assign sticky_hit = sticky_vld_q &&
                      ((sticky_id_q == HOST_LSU) ? h0_req_i : h1_req_i);

  always_comb begin
    win_vld = 1'b0;
    winner  = HOST_LSU;
    if (rst_ni) begin
      if (sticky_hit) begin
        win_vld = 1'b1;
        winner  = sticky_id_q;
      end else if (h0_req_i && h1_req_i) begin
        win_vld = 1'b1;
        winner  = both_pick;
      end else if (h0_req_i) begin
        win_vld = 1'b1;
        winner  = HOST_LSU;
      end else if (h1_req_i) begin
        win_vld = 1'b1;
        winner  = HOST_AUX;
      end
    end
  end

  always_comb begin
    data_addr_o  = '0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_wdata_o = '0;
    if (win_vld) begin
      if (winner == HOST_LSU) begin
        data_addr_o  = h0_addr_i;
        data_we_o    = h0_we_i;
        data_be_o    = h0_be_i;
        data_wdata_o = h0_wdata_i;
      end else begin
        data_addr_o  = h1_addr_i;
        data_we_o    = h1_we_i;
        data_be_o    = h1_be_i;
        data_wdata_o = h1_wdata_i;
      end
    end
  end

  // Full is judged on the registered count only, so rvalid never feeds req.
  assign data_req_o = win_vld && !fifo_full;
  assign handshake  = data_req_o && data_gnt_i;
  assign h0_gnt_o   = handshake && (winner == HOST_LSU);
  assign h1_gnt_o   = handshake && (winner == HOST_AUX);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sticky_vld_q <= 1'b0;
      sticky_id_q  <= HOST_LSU;
    end else begin
      sticky_vld_q <= data_req_o && !data_gnt_i;
      sticky_id_q  <= winner;
    end
  end

  ibex_dbus_arb_owner_fifo #(
    .Depth (MaxOutstanding)
  ) u_owner_fifo (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (handshake),
    .push_id_i (winner),
    .pop_i     (rsp_vld),
    .head_o    (head_id),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty),
    .count_o   (fifo_count)
  );

  assign rsp_vld     = rst_ni && data_rvalid_i && !fifo_empty;
  assign unexp_rsp_o = rst_ni && data_rvalid_i && fifo_empty;

  assign h0_rvalid_o = rsp_vld && (head_id == HOST_LSU);
  assign h1_rvalid_o = rsp_vld && (head_id == HOST_AUX);
  assign h0_err_o    = h0_rvalid_o && data_err_i;
  assign h1_err_o    = h1_rvalid_o && data_err_i;
  assign h0_rdata_o  = rst_ni ? data_rdata_i : '0;
  assign h1_rdata_o  = rst_ni ? data_rdata_i : '0;

  assign busy_o = rst_ni && (fifo_count != '0);

endmodule

// File: doc/ibex_data_bus_arb.md
Name: ibex_data_bus_arb

Overview:
Two-host arbiter that shares the core's single data-memory port between the load/store unit (host 0) and an auxiliary host (host 1, debug/DMA). Uses the req/gnt/rvalid data-bus protocol on all sides. Tracks the owner of each outstanding transaction in order, so responses are routed back to the correct host. Sits between the LSU and the top-level data_* interface.

Parameters:
MaxOutstanding, 2, maximum granted-but-unanswered transactions (1..4); sets owner-FIFO depth.

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
h0_req_i / h1_req_i  in  1  host request
h0_gnt_o / h1_gnt_o  out  1  host grant
h0_addr_i / h1_addr_i  in  32  word-aligned address
h0_we_i / h1_we_i  in  1  write enable
h0_be_i / h1_be_i  in  4  byte enables
h0_wdata_i / h1_wdata_i  in  32  write data
h0_rvalid_o / h1_rvalid_o  out  1  response valid
h0_rdata_o / h1_rdata_o  out  32  read data
h0_err_o / h1_err_o  out  1  response error
data_req_o  out  1  device request
data_gnt_i  in  1  device grant
data_addr_o  out  32  muxed address
data_we_o  out  1  muxed write enable
data_be_o  out  4  muxed byte enables
data_wdata_o  out  32  muxed write data
data_rvalid_i  in  1  device response valid
data_rdata_i  in  32  device read data
data_err_i  in  1  device error
busy_o  out  1  owner FIFO non-empty
unexp_rsp_o  out  1  one-cycle pulse: rvalid with empty FIFO

Behaviour:
- Reset: owner FIFO empty, no sticky selection, round-robin pointer = host 0. All outputs are 0 while reset is asserted.
- Selection (combinational):
  - If a sticky selection exists, it wins.
  - Otherwise the winner is chosen from the hosts requesting, per priority scheme.
  - The winner's addr/we/be/wdata drive data_*_o. When there is no winner, data_*_o are 0.
- data_req_o = winner exists AND FIFO not full. A pop in the same cycle does not relieve full; no rvalid->req path.
- Grant: hX_gnt_o = data_gnt_i AND data_req_o AND winner==X, in the same cycle (zero latency). The loser's gnt is 0.
- Sticky: if data_req_o=1 and data_gnt_i=0, the winner is registered as sticky. This keeps the request stable until granted. Sticky clears on grant.
- Hosts must hold req and payload until gnt. Dropping req while sticky is a protocol violation; the arbiter clears sticky if the sticky host's req is 0.
- Handshake (data_req_o and data_gnt_i): push the winner ID into the owner FIFO.
- Response (data_rvalid_i with FIFO non-empty):
  - Pop the head and assert hHead_rvalid_o, hHead_err_o = data_err_i, same cycle.
  - rdata goes to both hosts unmasked. Only rvalid/err are qualified.
- Same-cycle push and pop: both happen, count unchanged, ordering preserved. The push may enter an otherwise-empty FIFO while the pop is from an occupied one.
- Response with FIFO empty: dropped; unexp_rsp_o = 1 for that cycle; no host rvalid.
- Counter width: clog2(MaxOutstanding+1). Pointers wrap modulo MaxOutstanding.
- Reset mid-transaction: all state cleared; late device responses after reset raise unexp_rsp_o.
- busy_o = count != 0.

Optional Feature:
IBEX_DBUS_ARB_RR_EN:
- Defined: round-robin. The pointer flips to the other host after every handshake. When both request with no sticky, the host indicated by the pointer wins.
- Undefined: fixed priority, host 0 always wins; the pointer register is not instantiated.

Decomposition:
- Shared package ibex_dbus_arb_pkg:
  - host_id_e typedef (HOST_LSU=0, HOST_AUX=1).
  - MaxOutstandingLimit=4 constant.
- One sub-module, ibex_dbus_arb_owner_fifo: synchronous push/pop FIFO of host_id_e with full/empty/count outputs.

Test Plan:
- Single host 0 read: h0_req=1 addr 0x1000, gnt same cycle, rvalid next cycle rdata 0xDEADBEEF -> h0_gnt_o=1 cycle 0, h0_rvalid_o=1 with data cycle 1; h1 outputs stay 0.
- Both request continuously, gnt every cycle, MaxOutstanding=2, rvalid 1 cycle later:
  - RR build: grants alternate h0,h1,h0,h1.
  - Fixed build: h0 granted every cycle, h1 never.
  - Responses route in push order.
- Grant stall: h1 alone requests, data_gnt_i=0 for 3 cycles while h0 raises req in cycle 1 -> data_addr_o stays h1 address all 3 cycles; h1 granted cycle 3; h0 granted next.
- FIFO full: 2 grants, no rvalid -> data_req_o=0 despite req. rvalid with err=1 -> first owner gets err_o=1; data_req_o reasserts the next cycle, not the same cycle.
- Unexpected response: rvalid with empty FIFO -> unexp_rsp_o=1 one cycle; no host rvalid; busy_o=0.
- Reset after 1 outstanding grant, then rvalid -> FIFO empty after reset, unexp_rsp_o=1, no host rvalid.
